// File: rtl/program_counter_unit_if.sv
// Next-PC / instruction-fetch bundle for program_counter_unit.
// The master side is the PC unit itself (it issues fetch requests);
// the slave side is the surrounding core / instruction memory.
// Optional macro PC_BRANCH_COUNT_EN adds the takenBranchCount signal.
interface program_counter_unit_if;
  logic        nextPCSource;
  logic [31:0] branchTarget;
  logic        pcStall;
  logic        fetchReady;
  logic        fetchReq;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        misalignTrap;
  logic [31:0] excPC;
  logic [31:0] instrCount;
`ifdef PC_BRANCH_COUNT_EN
  logic [31:0] takenBranchCount;
`endif

  modport master (
    input  nextPCSource, branchTarget, pcStall, fetchReady,
    output fetchReq, pc, pcPlus4, misalignTrap, excPC, instrCount
`ifdef PC_BRANCH_COUNT_EN
    , output takenBranchCount
`endif
  );

  modport slave (
    output nextPCSource, branchTarget, pcStall, fetchReady,
    input  fetchReq, pc, pcPlus4, misalignTrap, excPC, instrCount
`ifdef PC_BRANCH_COUNT_EN
    , input takenBranchCount
`endif
  );
endinterface

// File: rtl/program_counter_unit.sv
// Program counter unit for the single-cycle core.
// Holds the architectural PC, selects PC+4 or the branch target coming from
// BranchUnit, drives instruction fetch with a req/ready handshake, traps on
// misaligned targets (one-cycle TRAP state, then resume at TRAP_VECTOR) and
// counts PC advances.
// Optional macro PC_BRANCH_COUNT_EN adds a taken-branch counter output.
module program_counter_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                   clk,
  input  logic                   rst,
  program_counter_unit_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pcState_t;

  pcState_t    state, stateNext;
  logic [31:0] pcReg, pcNext;
  logic [31:0] excPCReg, excPCNext;
  logic [31:0] countReg, countNext;
  logic        fetchReqC;
  logic        trapC;
  logic        advance;
  logic        misaligned;
  logic        takenC;

  // 32-bit address/counter increment; wrap-around modulo 2^32 is intended.
  function automatic logic [31:0] addWrap(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  assign misaligned = |bus.branchTarget[1:0];

  // State and architectural registers; all return to reset values immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pcReg    <= RESET_VECTOR;
      excPCReg <= 32'h0;
      countReg <= 32'h0;
    end else begin
      state    <= stateNext;
      pcReg    <= pcNext;
      excPCReg <= excPCNext;
      countReg <= countNext;
    end
  end

  // Next-state, next-PC and handshake decode; outputs depend on state only.
  always_comb begin
    stateNext = state;
    pcNext    = pcReg;
    excPCNext = excPCReg;
    countNext = countReg;
    fetchReqC = 1'b0;
    trapC     = 1'b0;
    advance   = 1'b0;
    takenC    = 1'b0;
    case (state)
      BOOT: begin
        stateNext = RUN;
      end
      RUN: begin
        fetchReqC = 1'b1;
        // pcStall dominates: a stalled cycle never advances, ready or not.
        advance   = fetchReqC & bus.fetchReady & ~bus.pcStall;
        if (advance) begin
          if (!bus.nextPCSource) begin
            pcNext    = addWrap(pcReg, 32'd4);
            countNext = addWrap(countReg, 32'd1);
          end else if (!misaligned) begin
            pcNext    = bus.branchTarget;
            countNext = addWrap(countReg, 32'd1);
            takenC    = 1'b1;
          end else begin
            // Faulting branch: keep pc, remember who faulted, do not count.
            excPCNext = pcReg;
            stateNext = TRAP;
          end
        end
      end
      TRAP: begin
        trapC     = 1'b1;
        pcNext    = TRAP_VECTOR;
        stateNext = RUN;
      end
      default: begin
        stateNext = BOOT;
      end
    endcase
  end

`ifdef PC_BRANCH_COUNT_EN
  logic [31:0] takenReg;

  // Taken-branch counter: aligned taken branches only, wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      takenReg <= 32'h0;
    end else if (takenC) begin
      takenReg <= addWrap(takenReg, 32'd1);
    end
  end

  assign bus.takenBranchCount = takenReg;
`else
  logic unusedTaken;
  assign unusedTaken = takenC;
`endif

  assign bus.fetchReq     = fetchReqC;
  assign bus.misalignTrap = trapC;
  assign bus.pc           = pcReg;
  assign bus.pcPlus4      = addWrap(pcReg, 32'd4);
  assign bus.excPC        = excPCReg;
  assign bus.instrCount   = countReg;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed self-checking bench for program_counter_unit.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_program_counter_unit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  program_counter_unit_if bus();

  program_counter_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic src, input logic [31:0] tgt, input logic stall, input logic rdy);
    bus.nextPCSource = src;
    bus.branchTarget = tgt;
    bus.pcStall      = stall;
    bus.fetchReady   = rdy;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    tick();

    // Reset state
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_pcPlus4", bus.pcPlus4, 32'h4);
    chk("rst_fetchReq", {31'b0, bus.fetchReq}, 32'h0);
    chk("rst_trap", {31'b0, bus.misalignTrap}, 32'h0);
    chk("rst_excPC", bus.excPC, 32'h0);
    chk("rst_count", bus.instrCount, 32'h0);
`ifdef PC_BRANCH_COUNT_EN
    chk("rst_taken", bus.takenBranchCount, 32'h0);
`endif

    // Release: BOOT cycle, then RUN, then sequential fetch
    rst = 1'b0;
    chk("boot_fetchReq", {31'b0, bus.fetchReq}, 32'h0);
    tick();
    chk("run_pc0", bus.pc, 32'h0);
    chk("run_fetchReq", {31'b0, bus.fetchReq}, 32'h1);
    tick();
    chk("seq_pc4", bus.pc, 32'h4);
    tick();
    chk("seq_pc8", bus.pc, 32'h8);
    tick();
    chk("seq_pcC", bus.pc, 32'hC);
    chk("seq_count3", bus.instrCount, 32'd3);
    tick();
    chk("seq_pc10", bus.pc, 32'h10);

    // Aligned taken branch 0x10 -> 0x40
    drive(1'b1, 32'h40, 1'b0, 1'b1);
    tick();
    chk("br_pc40", bus.pc, 32'h40);
    chk("br_count", bus.instrCount, 32'd5);
`ifdef PC_BRANCH_COUNT_EN
    chk("br_taken1", bus.takenBranchCount, 32'd1);
`endif

    // Branch to 0x20, then stall three cycles with a pending branch
    drive(1'b1, 32'h20, 1'b0, 1'b1);
    tick();
    chk("br_pc20", bus.pc, 32'h20);
    drive(1'b1, 32'h80, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", bus.pc, 32'h20);
      chk("stall_count", bus.instrCount, 32'd6);
    end
    // Not ready: also holds
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    tick();
    chk("nordy_pc", bus.pc, 32'h20);
    drive(1'b0, 32'h80, 1'b0, 1'b1);
    tick();
    chk("unstall_pc24", bus.pc, 32'h24);
    chk("unstall_count", bus.instrCount, 32'd7);

    // Misaligned branch from 0x30 -> one TRAP cycle, then 0x100
    drive(1'b1, 32'h30, 1'b0, 1'b1);
    tick();
    chk("br_pc30", bus.pc, 32'h30);
    drive(1'b1, 32'h46, 1'b0, 1'b1);
    tick();
    chk("trap_flag", {31'b0, bus.misalignTrap}, 32'h1);
    chk("trap_fetchReq", {31'b0, bus.fetchReq}, 32'h0);
    chk("trap_excPC", bus.excPC, 32'h30);
    chk("trap_pc", bus.pc, 32'h30);
    chk("trap_count", bus.instrCount, 32'd8);
`ifdef PC_BRANCH_COUNT_EN
    chk("trap_taken", bus.takenBranchCount, 32'd3);
`endif
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("post_trap_pc", bus.pc, 32'h100);
    chk("post_trap_flag", {31'b0, bus.misalignTrap}, 32'h0);
    chk("post_trap_fetchReq", {31'b0, bus.fetchReq}, 32'h1);
    chk("post_trap_count", bus.instrCount, 32'd8);
    chk("post_trap_excPC", bus.excPC, 32'h30);

    // PC wrap at top of address space
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    tick();
    chk("top_pc", bus.pc, 32'hFFFF_FFFC);
    chk("top_pcPlus4", bus.pcPlus4, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("wrap_pc", bus.pc, 32'h0);
    chk("wrap_pcPlus4", bus.pcPlus4, 32'h4);
    chk("wrap_count", bus.instrCount, 32'd10);
`ifdef PC_BRANCH_COUNT_EN
    chk("wrap_taken", bus.takenBranchCount, 32'd4);
`endif

    // Async reset in the middle of a TRAP cycle at pc 0x50
    drive(1'b1, 32'h50, 1'b0, 1'b1);
    tick();
    chk("br_pc50", bus.pc, 32'h50);
    drive(1'b1, 32'h52, 1'b0, 1'b1);
    tick();
    chk("trap2_flag", {31'b0, bus.misalignTrap}, 32'h1);
    chk("trap2_excPC", bus.excPC, 32'h50);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", bus.pc, 32'h0);
    chk("arst_trap", {31'b0, bus.misalignTrap}, 32'h0);
    chk("arst_excPC", bus.excPC, 32'h0);
    chk("arst_count", bus.instrCount, 32'h0);
    chk("arst_fetchReq", {31'b0, bus.fetchReq}, 32'h0);
`ifdef PC_BRANCH_COUNT_EN
    chk("arst_taken", bus.takenBranchCount, 32'h0);
`endif

    // Recover after reset: BOOT then RUN then advance
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    chk("rec_pc0", bus.pc, 32'h0);
    tick();
    chk("rec_pc4", bus.pc, 32'h4);
    chk("rec_count", bus.instrCount, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
